// File: rtl/snake_pkg.sv
// Shared definitions for the snake display path.
// Holds the screen geometry, the coordinate and colour widths, the colour
// used by the background clear, and the arbiter state encoding.
package snake_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int COORD_XW = 8;
    localparam int COORD_YW = 7;
    localparam int COLOUR_W = 3;

    localparam logic [COLOUR_W-1:0] BG_COLOUR = 3'b000;

    // CLEAR: full-screen background sweep owns the plot port.
    // RUN:   snake/food requesters share the port through the arbiter.
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } arb_state_t;

endpackage

// File: rtl/clear_sweeper.sv
// Raster counter for the background clear.
// Walks (0,0)..(W-1,H-1) with x fastest, one step per cycle while active.
// Ports:
//   clk, rst   clock, synchronous active-high reset (counters -> 0,0)
//   start      zero the counters (entry into a new sweep)
//   active     advance one pixel this cycle
//   x, y       current sweep pixel
//   last       current pixel is (W-1,H-1)
module clear_sweeper
    import snake_pkg::*;
#(
    parameter int W  = SCREEN_W,
    parameter int H  = SCREEN_H,
    parameter int XW = COORD_XW,
    parameter int YW = COORD_YW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          active,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last
);

    localparam logic [XW-1:0] X_LAST = XW'(W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(H - 1);

    logic x_wrap;
    logic y_wrap;

    assign x_wrap = (x == X_LAST);
    assign y_wrap = (y == Y_LAST);
    assign last   = x_wrap && y_wrap;

    // Counters never count past W-1 / H-1, so no step overflows XW/YW bits.
    always_ff @(posedge clk) begin
        if (rst || start) begin
            x <= '0;
            y <= '0;
        end else if (active) begin
            if (x_wrap) begin
                x <= '0;
                y <= y_wrap ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/plot_arbiter.sv
// Owner of the single VGA plot port.
// After reset (or on clear_req) it sweeps the whole screen with BG_COLOUR,
// then shares the port between the snake and food renderers with a
// round-robin valid/ready handshake. All VGA outputs are registered.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   clear_req                      start a sweep (honoured only in RUN)
//   s_valid/s_x/s_y/s_colour       snake pixel request, s_ready = accepted
//   f_valid/f_x/f_y/f_colour       food pixel request,  f_ready = accepted
//   x_out/y_out/colour_out/plot    VGA pixel and write enable
//   busy                           high while sweeping
//   clear_done                     pulse while the last sweep pixel is out
//   oob_drop                       pulse when an off-screen pixel was dropped
module plot_arbiter
#(
    parameter int W  = snake_pkg::SCREEN_W,
    parameter int H  = snake_pkg::SCREEN_H,
    parameter int XW = snake_pkg::COORD_XW,
    parameter int YW = snake_pkg::COORD_YW,
    parameter int CW = snake_pkg::COLOUR_W,
    parameter logic [CW-1:0] BG_COLOUR = snake_pkg::BG_COLOUR
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear_req,
    input  logic          s_valid,
    input  logic [XW-1:0] s_x,
    input  logic [YW-1:0] s_y,
    input  logic [CW-1:0] s_colour,
    output logic          s_ready,
    input  logic          f_valid,
    input  logic [XW-1:0] f_x,
    input  logic [YW-1:0] f_y,
    input  logic [CW-1:0] f_colour,
    output logic          f_ready,
    output logic [XW-1:0] x_out,
    output logic [YW-1:0] y_out,
    output logic [CW-1:0] colour_out,
    output logic          plot,
    output logic          busy,
    output logic          clear_done,
    output logic          oob_drop
);

    import snake_pkg::arb_state_t;
    import snake_pkg::CLEAR;
    import snake_pkg::RUN;

    // One extra bit so the limits W and H themselves are representable.
    localparam logic [XW:0] X_LIM = (XW + 1)'(W);
    localparam logic [YW:0] Y_LIM = (YW + 1)'(H);

    arb_state_t    state_q;
    arb_state_t    state_d;
    logic          prio_food;     // 1: food wins the next contested cycle
    logic          sweep_start;
    logic          sweep_active;
    logic          sweep_last;
    logic [XW-1:0] sweep_x;
    logic [YW-1:0] sweep_y;
    logic          xfer;
    logic [XW-1:0] sel_x;
    logic [YW-1:0] sel_y;
    logic [CW-1:0] sel_colour;
    logic          sel_oob;

    assign sweep_active = (state_q == CLEAR);
    assign sweep_start  = (state_q == RUN) && clear_req;
    assign busy         = (state_q == CLEAR);

    clear_sweeper #(
        .W  (W),
        .H  (H),
        .XW (XW),
        .YW (YW)
    ) u_sweeper (
        .clk    (clk),
        .rst    (rst),
        .start  (sweep_start),
        .active (sweep_active),
        .x      (sweep_x),
        .y      (sweep_y),
        .last   (sweep_last)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: the sweep ends on its last pixel; a clear request only
    // counts in RUN, so a request during a sweep does not restart it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            CLEAR:   if (sweep_last) state_d = RUN;
            RUN:     if (clear_req)  state_d = CLEAR;
            default: state_d = CLEAR;
        endcase
    end

    // Grants. clear_req suppresses grants in its own cycle so a pending
    // requester simply waits out the sweep without being accepted.
    always_comb begin
        s_ready = 1'b0;
        f_ready = 1'b0;
        if (state_q == RUN && !clear_req) begin
            if (s_valid && (!f_valid || !prio_food)) begin
                s_ready = 1'b1;
            end else if (f_valid) begin
                f_ready = 1'b1;
            end
        end
    end

    assign xfer       = s_ready || f_ready;
    assign sel_x      = s_ready ? s_x      : f_x;
    assign sel_y      = s_ready ? s_y      : f_y;
    assign sel_colour = s_ready ? s_colour : f_colour;
    assign sel_oob    = ({1'b0, sel_x} >= X_LIM) || ({1'b0, sel_y} >= Y_LIM);

    // Round-robin pointer: moves only on a completed transfer, including
    // transfers of off-screen pixels that are then dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_food <= 1'b0;
        end else if (s_ready) begin
            prio_food <= 1'b1;
        end else if (f_ready) begin
            prio_food <= 1'b0;
        end
    end

    // Output registers. Coordinates and colour hold when nothing is plotted,
    // including the cycle after an off-screen pixel is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_out      <= '0;
            y_out      <= '0;
            colour_out <= '0;
            plot       <= 1'b0;
            clear_done <= 1'b0;
            oob_drop   <= 1'b0;
        end else begin
            plot       <= 1'b0;
            clear_done <= 1'b0;
            oob_drop   <= 1'b0;
            if (state_q == CLEAR) begin
                x_out      <= sweep_x;
                y_out      <= sweep_y;
                colour_out <= BG_COLOUR;
                plot       <= 1'b1;
                clear_done <= sweep_last;
            end else if (xfer) begin
                if (sel_oob) begin
                    oob_drop <= 1'b1;
                end else begin
                    x_out      <= sel_x;
                    y_out      <= sel_y;
                    colour_out <= sel_colour;
                    plot       <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_plot_arbiter.sv
module tb_plot_arbiter;

    localparam int NPIX = 160 * 120;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear_req;
    logic       s_valid, f_valid;
    logic [7:0] s_x, f_x;
    logic [6:0] s_y, f_y;
    logic [2:0] s_colour, f_colour;
    logic       s_ready, f_ready;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour_out;
    logic       plot, busy, clear_done, oob_drop;

    int checks   = 0;
    int failures = 0;

    // Reference model state: who wins the next contested cycle, and what the
    // held VGA coordinates/colour should be.
    bit         m_prio_food;
    logic [7:0] e_x;
    logic [6:0] e_y;
    logic [2:0] e_c;

    plot_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .clear_req  (clear_req),
        .s_valid    (s_valid),
        .s_x        (s_x),
        .s_y        (s_y),
        .s_colour   (s_colour),
        .s_ready    (s_ready),
        .f_valid    (f_valid),
        .f_x        (f_x),
        .f_y        (f_y),
        .f_colour   (f_colour),
        .f_ready    (f_ready),
        .x_out      (x_out),
        .y_out      (y_out),
        .colour_out (colour_out),
        .plot       (plot),
        .busy       (busy),
        .clear_done (clear_done),
        .oob_drop   (oob_drop)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Returns {f_grant, s_grant}
    function automatic logic [1:0] model_grant(input bit sv, input bit fv);
        if (sv && fv) return m_prio_food ? 2'b10 : 2'b01;
        if (sv) return 2'b01;
        if (fv) return 2'b10;
        return 2'b00;
    endfunction

    function automatic bit is_oob(input logic [7:0] x, input logic [6:0] y);
        return (int'(x) >= 160) || (int'(y) >= 120);
    endfunction

    task automatic test_reset();
        int bad = 0, dones = 0, done_at = -1;
        rst = 1; clear_req = 0;
        s_valid = 1; f_valid = 1;
        s_x = 8'd1; s_y = 7'd1; s_colour = 3'd1;
        f_x = 8'd2; f_y = 7'd2; f_colour = 3'd2;
        cyc(); cyc();
        checks++;
        if (plot !== 1'b0 || clear_done !== 1'b0 || oob_drop !== 1'b0 ||
            x_out !== 8'd0 || y_out !== 7'd0 || colour_out !== 3'd0)
            begin failures++; $display("FAIL reset_outputs got plot=%b done=%b oob=%b x=%0d y=%0d c=%0d exp all 0",
                                       plot, clear_done, oob_drop, x_out, y_out, colour_out); end
        checks++;
        if (busy !== 1'b1 || s_ready !== 1'b0 || f_ready !== 1'b0)
            begin failures++; $display("FAIL reset_busy_grants got busy=%b s_ready=%b f_ready=%b exp 1 0 0",
                                       busy, s_ready, f_ready); end
        s_valid = 0; f_valid = 0;
        rst = 0; m_prio_food = 0;
        for (int n = 0; n < NPIX; n++) begin
            cyc();
            if (plot !== 1'b1 || x_out !== 8'(n % 160) || y_out !== 7'(n / 160) ||
                colour_out !== 3'd0 || busy !== (n != NPIX - 1)) bad++;
            if (clear_done === 1'b1) begin dones++; done_at = n; end
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL sweep_pixels got %0d bad pixels exp 0", bad); end
        checks++;
        if (dones != 1 || done_at != NPIX - 1)
            begin failures++; $display("FAIL sweep_done got pulses=%0d at=%0d exp 1 at %0d", dones, done_at, NPIX - 1); end
        cyc();
        checks++;
        if (plot !== 1'b0 || busy !== 1'b0 || clear_done !== 1'b0)
            begin failures++; $display("FAIL sweep_end got plot=%b busy=%b done=%b exp 0 0 0", plot, busy, clear_done); end
        e_x = 8'd159; e_y = 7'd119; e_c = 3'd0;
    endtask

    task automatic test_alternate();
        logic [1:0] g;
        s_valid = 1; f_valid = 1;
        s_x = 8'($urandom_range(0, 159)); s_y = 7'($urandom_range(0, 119)); s_colour = 3'($urandom_range(0, 7));
        f_x = 8'($urandom_range(0, 159)); f_y = 7'($urandom_range(0, 119)); f_colour = 3'($urandom_range(0, 7));
        for (int i = 0; i < 6; i++) begin
            #1;
            g = (i % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if ({f_ready, s_ready} !== g)
                begin failures++; $display("FAIL alt_grant[%0d] got f/s=%b exp %b", i, {f_ready, s_ready}, g); end
            if (g[0]) begin e_x = s_x; e_y = s_y; e_c = s_colour; m_prio_food = 1; end
            else      begin e_x = f_x; e_y = f_y; e_c = f_colour; m_prio_food = 0; end
            cyc();
            checks++;
            if (plot !== 1'b1 || x_out !== e_x || y_out !== e_y || colour_out !== e_c)
                begin failures++; $display("FAIL alt_out[%0d] got plot=%b (%0d,%0d,%0d) exp 1 (%0d,%0d,%0d)",
                                           i, plot, x_out, y_out, colour_out, e_x, e_y, e_c); end
            if (g[0]) begin s_x = 8'($urandom_range(0, 159)); s_y = 7'($urandom_range(0, 119)); s_colour = 3'($urandom_range(0, 7)); end
            else      begin f_x = 8'($urandom_range(0, 159)); f_y = 7'($urandom_range(0, 119)); f_colour = 3'($urandom_range(0, 7)); end
        end
        s_valid = 0; f_valid = 0;
        cyc();
    endtask

    task automatic test_single();
        s_valid = 1; s_x = 8'd10; s_y = 7'd20; s_colour = 3'b100;
        f_valid = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (s_ready !== 1'b1 || f_ready !== 1'b0)
                begin failures++; $display("FAIL single_grant[%0d] got s=%b f=%b exp 1 0", i, s_ready, f_ready); end
            cyc();
            checks++;
            if (plot !== 1'b1 || x_out !== 8'd10 || y_out !== 7'd20 || colour_out !== 3'b100)
                begin failures++; $display("FAIL single_out[%0d] got plot=%b (%0d,%0d,%0d) exp 1 (10,20,4)",
                                           i, plot, x_out, y_out, colour_out); end
        end
        m_prio_food = 1;
        e_x = 8'd10; e_y = 7'd20; e_c = 3'b100;
        s_valid = 0;
        #1;
        checks++;
        if (s_ready !== 1'b0) begin failures++; $display("FAIL single_idle_ready got %b exp 0", s_ready); end
        cyc();
        checks++;
        if (plot !== 1'b0 || x_out !== e_x || y_out !== e_y || colour_out !== e_c)
            begin failures++; $display("FAIL single_hold got plot=%b (%0d,%0d,%0d) exp 0 (%0d,%0d,%0d)",
                                       plot, x_out, y_out, colour_out, e_x, e_y, e_c); end
    endtask

    task automatic test_oob();
        // Food at x=W: accepted, then dropped.
        f_valid = 1; f_x = 8'd160; f_y = 7'd5; f_colour = 3'd7;
        #1;
        checks++;
        if (f_ready !== 1'b1) begin failures++; $display("FAIL oob_x_ready got %b exp 1", f_ready); end
        cyc();
        f_valid = 0; m_prio_food = 0;
        checks++;
        if (plot !== 1'b0 || oob_drop !== 1'b1 || x_out !== e_x || y_out !== e_y || colour_out !== e_c)
            begin failures++; $display("FAIL oob_x_drop got plot=%b oob=%b (%0d,%0d) exp 0 1 (%0d,%0d)",
                                       plot, oob_drop, x_out, y_out, e_x, e_y); end
        cyc();
        checks++;
        if (oob_drop !== 1'b0 || plot !== 1'b0)
            begin failures++; $display("FAIL oob_pulse got oob=%b plot=%b exp 0 0", oob_drop, plot); end
        // Snake at y=H.
        s_valid = 1; s_x = 8'd5; s_y = 7'd120; s_colour = 3'd3;
        #1;
        checks++;
        if (s_ready !== 1'b1) begin failures++; $display("FAIL oob_y_ready got %b exp 1", s_ready); end
        cyc();
        s_valid = 0; m_prio_food = 1;
        checks++;
        if (plot !== 1'b0 || oob_drop !== 1'b1 || x_out !== e_x || y_out !== e_y)
            begin failures++; $display("FAIL oob_y_drop got plot=%b oob=%b (%0d,%0d) exp 0 1 (%0d,%0d)",
                                       plot, oob_drop, x_out, y_out, e_x, e_y); end
        // Last on-screen pixel is plotted.
        f_valid = 1; f_x = 8'd159; f_y = 7'd119; f_colour = 3'd6;
        #1;
        cyc();
        f_valid = 0; m_prio_food = 0;
        e_x = 8'd159; e_y = 7'd119; e_c = 3'd6;
        checks++;
        if (plot !== 1'b1 || oob_drop !== 1'b0 || x_out !== e_x || y_out !== e_y || colour_out !== e_c)
            begin failures++; $display("FAIL edge_pixel got plot=%b oob=%b (%0d,%0d,%0d) exp 1 0 (159,119,6)",
                                       plot, oob_drop, x_out, y_out, colour_out); end
    endtask

    task automatic test_random();
        bit sp = 0, fp = 0, ex_plot, ex_oob;
        logic [7:0] sx = 0, fx = 0;
        logic [6:0] sy = 0, fy = 0;
        logic [2:0] sc = 0, fc = 0;
        logic [1:0] g;
        for (int i = 0; i < 400; i++) begin
            if (!sp && $urandom_range(0, 1) == 1) begin
                sp = 1; sx = 8'($urandom_range(0, 175)); sy = 7'($urandom_range(0, 127)); sc = 3'($urandom_range(0, 7));
            end
            if (!fp && $urandom_range(0, 1) == 1) begin
                fp = 1; fx = 8'($urandom_range(0, 175)); fy = 7'($urandom_range(0, 127)); fc = 3'($urandom_range(0, 7));
            end
            s_valid = sp; s_x = sx; s_y = sy; s_colour = sc;
            f_valid = fp; f_x = fx; f_y = fy; f_colour = fc;
            #1;
            g = model_grant(sp, fp);
            checks++;
            if ({f_ready, s_ready} !== g)
                begin failures++; $display("FAIL rand_grant[%0d] got f/s=%b exp %b", i, {f_ready, s_ready}, g); end
            ex_plot = 0; ex_oob = 0;
            if (g == 2'b01) begin
                if (is_oob(sx, sy)) ex_oob = 1;
                else begin ex_plot = 1; e_x = sx; e_y = sy; e_c = sc; end
                m_prio_food = 1; sp = 0;
            end else if (g == 2'b10) begin
                if (is_oob(fx, fy)) ex_oob = 1;
                else begin ex_plot = 1; e_x = fx; e_y = fy; e_c = fc; end
                m_prio_food = 0; fp = 0;
            end
            cyc();
            checks++;
            if (plot !== ex_plot || oob_drop !== ex_oob || x_out !== e_x || y_out !== e_y || colour_out !== e_c)
                begin failures++; $display("FAIL rand_out[%0d] got plot=%b oob=%b (%0d,%0d,%0d) exp %b %b (%0d,%0d,%0d)",
                                           i, plot, oob_drop, x_out, y_out, colour_out, ex_plot, ex_oob, e_x, e_y, e_c); end
        end
        s_valid = 0; f_valid = 0;
        cyc();
    endtask

    task automatic test_clear_req();
        int bad = 0, early = 0, dones = 0;
        s_valid = 1; s_x = 8'd33; s_y = 7'd44; s_colour = 3'd2;
        f_valid = 0;
        clear_req = 1;
        #1;
        checks++;
        if (s_ready !== 1'b0) begin failures++; $display("FAIL clear_wins got s_ready=%b exp 0", s_ready); end
        cyc();
        clear_req = 0;
        checks++;
        if (plot !== 1'b0 || busy !== 1'b1)
            begin failures++; $display("FAIL clear_entry got plot=%b busy=%b exp 0 1", plot, busy); end
        for (int k = 1; k <= NPIX; k++) begin
            clear_req = (k == 100);   // ignored while sweeping
            #1;
            if (s_ready !== 1'b0) early++;
            cyc();
            if (plot !== 1'b1 || x_out !== 8'((k - 1) % 160) || y_out !== 7'((k - 1) / 160) || colour_out !== 3'd0) bad++;
            if (clear_done === 1'b1) begin
                if (k - 1 == NPIX - 1) dones++; else dones += 100;
            end
        end
        clear_req = 0;
        checks++;
        if (early != 0) begin failures++; $display("FAIL clear_hold_ready got %0d early grants exp 0", early); end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL clear_pixels got %0d bad pixels exp 0", bad); end
        checks++;
        if (dones != 1) begin failures++; $display("FAIL clear_done_pulse got code=%0d exp 1", dones); end
        #1;
        checks++;
        if (s_ready !== 1'b1 || busy !== 1'b0)
            begin failures++; $display("FAIL post_clear_grant got s_ready=%b busy=%b exp 1 0", s_ready, busy); end
        cyc();
        s_valid = 0; m_prio_food = 1;
        e_x = 8'd33; e_y = 7'd44; e_c = 3'd2;
        checks++;
        if (plot !== 1'b1 || x_out !== e_x || y_out !== e_y || colour_out !== e_c)
            begin failures++; $display("FAIL post_clear_plot got plot=%b (%0d,%0d,%0d) exp 1 (33,44,2)",
                                       plot, x_out, y_out, colour_out); end
    endtask

    task automatic test_reset_mid_sweep();
        int bad = 0, dones = 0, done_at = -1;
        rst = 1;
        cyc();
        rst = 0; m_prio_food = 0;
        for (int n = 0; n <= 5000; n++) begin
            cyc();
            if (plot !== 1'b1 || x_out !== 8'(n % 160) || y_out !== 7'(n / 160)) bad++;
            if (clear_done === 1'b1) dones++;
        end
        checks++;
        if (bad != 0 || dones != 0)
            begin failures++; $display("FAIL partial_sweep got bad=%0d done_pulses=%0d exp 0 0", bad, dones); end
        rst = 1;
        cyc();
        rst = 0;
        checks++;
        if (plot !== 1'b0 || clear_done !== 1'b0 || x_out !== 8'd0 || y_out !== 7'd0 || busy !== 1'b1)
            begin failures++; $display("FAIL mid_reset got plot=%b done=%b (%0d,%0d) busy=%b exp 0 0 (0,0) 1",
                                       plot, clear_done, x_out, y_out, busy); end
        bad = 0; dones = 0;
        for (int n = 0; n < NPIX; n++) begin
            cyc();
            if (plot !== 1'b1 || x_out !== 8'(n % 160) || y_out !== 7'(n / 160) || colour_out !== 3'd0) bad++;
            if (clear_done === 1'b1) begin dones++; done_at = n; end
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL restart_pixels got %0d bad pixels exp 0", bad); end
        checks++;
        if (dones != 1 || done_at != NPIX - 1)
            begin failures++; $display("FAIL restart_done got pulses=%0d at=%0d exp 1 at %0d", dones, done_at, NPIX - 1); end
        // Pointer was on food before the reset; reset puts it back on snake.
        s_valid = 1; s_x = 8'd1; s_y = 7'd2; s_colour = 3'd3;
        f_valid = 1; f_x = 8'd4; f_y = 7'd5; f_colour = 3'd6;
        #1;
        checks++;
        if ({f_ready, s_ready} !== model_grant(1, 1))
            begin failures++; $display("FAIL reset_pointer got f/s=%b exp %b", {f_ready, s_ready}, model_grant(1, 1)); end
        cyc();
        s_valid = 0; f_valid = 0;
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_single();
        test_oob();
        test_random();
        test_clear_req();
        test_reset_mid_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
